quan_mult_scheduler: RTL and testbench

- Sequences the quantisation sum×E stage: accepts systolic-array column sum vectors, looks up the per-output-channel E_scale pair, and drives mode/E_set/issue strobes into the sum×E operand formatter and the shared multiplier array.
- Tracks the fixed-latency multiplier pipeline and emits tagged result-valid strobes.
- Throttles issue with a credit counter so the downstream result FIFO never overflows.
- Sits between the SA output collector and the requant/store stage.

---
 rtl/quan_mult_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_quan_mult_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quan_mult_scheduler.sv
// quan_mult_scheduler
// Sequences the quantisation sum x E stage. It accepts column-sum vectors,
// looks up the per-channel E_scale pair, drives mode/E_set/issue into the
// operand formatter and multiplier, and tracks the fixed-latency multiplier
// pipe to emit tagged result strobes. Issue is throttled by a credit counter
// that mirrors the free slots of the downstream result FIFO.
//
// Optional build macro: QUAN_SCHED_PERF_CNT_EN adds stall_cnt / active_cnt.
//
// state | meaning
// IDLE  | waiting for start; config latched on a legal start
// RUN   | accepting sum vectors while credits remain
// DRAIN | every channel issued; waiting for the final product
// DONE  | one-cycle done pulse, then back to IDLE
module quan_mult_scheduler #(
  parameter int E_WIDTH  = 16,
  parameter int E_DEPTH  = 256,
  parameter int OCH_W    = 8,
  parameter int MULT_LAT = 4,
  parameter int CREDITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           cfg_mode,
  input  logic [OCH_W:0]       cfg_och_num,
  input  logic                 e_wr_en,
  input  logic [OCH_W-1:0]     e_wr_addr,
  input  logic [E_WIDTH-1:0]   e_wr_data,
  input  logic                 sum_valid,
  output logic                 sum_ready,
  output logic [3:0]           mode_out,
  output logic [2*E_WIDTH-1:0] E_set_out,
  output logic                 issue,
  output logic                 res_valid,
  output logic [OCH_W-1:0]     res_och,
  output logic                 res_last,
  input  logic                 res_credit_ret,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
`ifdef QUAN_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          active_cnt
`endif
);

  localparam int CR_W  = $clog2(CREDITS + 1);
  localparam int LAT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [E_WIDTH-1:0] e_mem [E_DEPTH];
  logic [OCH_W-1:0]   e_idx_lo, e_idx_hi;
  logic [E_WIDTH-1:0] e_lo, e_hi;

  logic [3:0]       mode_r;
  logic [OCH_W:0]   och_num_r;
  logic [OCH_W:0]   och_ptr;
  logic [OCH_W+1:0] step, ptr_next;
  logic [CR_W-1:0]  credits;
  logic [LAT_W-1:0] drain_tmr;
  logic             cfg_legal, start_idle, hs, last_hs;

  logic [OCH_W-1:0] issue_och;
  logic             issue_last;
  logic [MULT_LAT-1:0] pipe_v, pipe_l;
  logic [OCH_W-1:0]    pipe_och [MULT_LAT];

  // A zero-length tile would never leave RUN, so it is rejected with the
  // other illegal configurations.
  assign cfg_legal = ((cfg_mode == 4'd0) || ((cfg_mode == 4'd1) && !cfg_och_num[0]))
                     && (cfg_och_num != '0)
                     && ({1'b0, cfg_och_num} <= (OCH_W+2)'(E_DEPTH));
  assign start_idle = start && (state == S_IDLE);

  assign sum_ready = (state == S_RUN) && (credits != '0);
  assign hs        = sum_valid && sum_ready;
  assign step      = mode_r[0] ? (OCH_W+2)'(2) : (OCH_W+2)'(1);
  assign ptr_next  = {1'b0, och_ptr} + step;
  assign last_hs   = hs && (ptr_next == {1'b0, och_num_r});

  assign e_idx_lo = och_ptr[OCH_W-1:0];
  assign e_idx_hi = och_ptr[OCH_W-1:0] + OCH_W'(1);
  assign e_lo     = e_mem[e_idx_lo];
  assign e_hi     = e_mem[e_idx_hi];

  assign res_valid = pipe_v[MULT_LAT-1];
  assign res_och   = pipe_och[MULT_LAT-1];
  assign res_last  = pipe_l[MULT_LAT-1];

  // E table write port; reads are combinational so a same-cycle write is
  // only visible from the next cycle on.
  always_ff @(posedge clk) begin
    if (e_wr_en) e_mem[e_wr_addr] <= e_wr_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && cfg_legal) state_nxt = S_RUN;
      end
      S_RUN:   if (last_hs) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_tmr == '0) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config latch, channel pointer and sticky config error
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r    <= '0;
      och_num_r <= '0;
      och_ptr   <= '0;
      cfg_err   <= 1'b0;
    end else if (start_idle) begin
      if (cfg_legal) begin
        mode_r    <= cfg_mode;
        och_num_r <= cfg_och_num;
        och_ptr   <= '0;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err   <= 1'b1;
      end
    end else if (hs) begin
      och_ptr <= ptr_next[OCH_W:0];
    end
  end

  // Drain timer: the last product leaves the pipe MULT_LAT cycles after its
  // issue, which is exactly when DONE is entered.
  always_ff @(posedge clk) begin
    if (rst)                                    drain_tmr <= '0;
    else if (last_hs)                           drain_tmr <= LAT_W'(MULT_LAT - 1);
    else if (state == S_DRAIN && drain_tmr != '0) drain_tmr <= drain_tmr - LAT_W'(1);
  end

  // Credit counter; a simultaneous take and return cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CR_W'(CREDITS);
    end else if (hs && !res_credit_ret) begin
      credits <= credits - CR_W'(1);
    end else if (!hs && res_credit_ret && credits != CR_W'(CREDITS)) begin
      credits <= credits + CR_W'(1);
    end
  end

  // Operand stage: mode/E_set captured on the handshake, presented with issue
  always_ff @(posedge clk) begin
    if (rst) begin
      issue      <= 1'b0;
      mode_out   <= '0;
      E_set_out  <= '0;
      issue_och  <= '0;
      issue_last <= 1'b0;
    end else begin
      issue <= hs;
      if (hs) begin
        mode_out   <= mode_r;
        E_set_out  <= mode_r[0] ? {e_hi, e_lo} : {{E_WIDTH{1'b0}}, e_lo};
        issue_och  <= och_ptr[OCH_W-1:0];
        issue_last <= last_hs;
      end
    end
  end

  // Multiplier latency pipe; tags are zeroed on empty slots
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      pipe_l <= '0;
      for (int i = 0; i < MULT_LAT; i++) pipe_och[i] <= '0;
    end else begin
      pipe_v[0]   <= issue;
      pipe_l[0]   <= issue && issue_last;
      pipe_och[0] <= issue ? issue_och : '0;
      for (int i = 1; i < MULT_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_l[i]   <= pipe_l[i-1];
        pipe_och[i] <= pipe_och[i-1];
      end
    end
  end

`ifdef QUAN_SCHED_PERF_CNT_EN
  // Performance counters, cleared by any start seen in IDLE
  always_ff @(posedge clk) begin
    if (rst || start_idle) begin
      stall_cnt  <= '0;
      active_cnt <= '0;
    end else begin
      if (state == S_RUN || state == S_DRAIN) active_cnt <= active_cnt + 32'd1;
      if (state == S_RUN && sum_valid && !sum_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quan_mult_scheduler.sv
// Testbench for quan_mult_scheduler: directed test-plan scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_quan_mult_scheduler;
  localparam int E_WIDTH  = 16;
  localparam int E_DEPTH  = 256;
  localparam int OCH_W    = 8;
  localparam int MULT_LAT = 4;
  localparam int CREDITS  = 8;

  logic clk = 1'b0;
  logic rst, start, e_wr_en, sum_valid, res_credit_ret;
  logic [3:0] cfg_mode;
  logic [OCH_W:0] cfg_och_num;
  logic [OCH_W-1:0] e_wr_addr;
  logic [E_WIDTH-1:0] e_wr_data;
  logic sum_ready, issue, res_valid, res_last, busy, done, cfg_err;
  logic [3:0] mode_out;
  logic [2*E_WIDTH-1:0] E_set_out;
  logic [OCH_W-1:0] res_och;
`ifdef QUAN_SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt, active_cnt;
`endif

  quan_mult_scheduler #(.E_WIDTH(E_WIDTH), .E_DEPTH(E_DEPTH), .OCH_W(OCH_W),
                        .MULT_LAT(MULT_LAT), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_och_num(cfg_och_num),
    .e_wr_en(e_wr_en), .e_wr_addr(e_wr_addr), .e_wr_data(e_wr_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .mode_out(mode_out), .E_set_out(E_set_out),
    .issue(issue), .res_valid(res_valid), .res_och(res_och), .res_last(res_last),
    .res_credit_ret(res_credit_ret), .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef QUAN_SCHED_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .active_cnt(active_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  // Reference model: tile progress, credits, E table and timed expectations
  logic [E_WIDTH-1:0] etab [E_DEPTH];
  bit m_run, m_drain, m_err;
  int m_ptr, m_num, m_mode, m_cred, m_done_cyc;
  bit                 exp_iss [int];
  logic [31:0]        exp_es  [int];
  logic [3:0]         exp_md  [int];
  bit                 exp_rv  [int];
  logic [OCH_W-1:0]   exp_ro  [int];
  bit                 exp_rl  [int];
  bit                 exp_dn  [int];

  // Advance one clock, first applying this cycle's inputs to the model
  task automatic clk_cycle();
    bit idle, hs, legal;
    int och, rc;
    idle = !m_run && !m_drain;
    hs = 1'b0;
    if (rst) begin
      m_run = 0; m_drain = 0; m_err = 0; m_cred = CREDITS;
      exp_iss.delete(); exp_es.delete(); exp_md.delete();
      exp_rv.delete(); exp_ro.delete(); exp_rl.delete(); exp_dn.delete();
    end else begin
      if (m_run) begin
        hs = sum_valid && (m_cred > 0);
        if (hs) begin
          och = m_ptr;
          exp_iss[k+1] = 1'b1;
          exp_md[k+1]  = 4'(m_mode);
          exp_es[k+1]  = (m_mode == 1) ? {etab[och+1], etab[och]} : {16'h0000, etab[och]};
          m_ptr = m_ptr + ((m_mode == 1) ? 2 : 1);
          rc = k + 1 + MULT_LAT;
          exp_rv[rc] = 1'b1;
          exp_ro[rc] = OCH_W'(och);
          exp_rl[rc] = (m_ptr == m_num);
          if (m_ptr == m_num) begin
            m_run = 0; m_drain = 1; m_done_cyc = rc; exp_dn[rc] = 1'b1;
          end
        end
      end else if (m_drain && k >= m_done_cyc) begin
        m_drain = 0;
      end
      if (hs && !res_credit_ret) m_cred--;
      else if (!hs && res_credit_ret && m_cred < CREDITS) m_cred++;
      if (start && idle) begin
        legal = ((cfg_mode == 0) || (cfg_mode == 1 && cfg_och_num[0] == 1'b0))
                && (cfg_och_num >= 1) && (cfg_och_num <= E_DEPTH);
        if (legal) begin
          m_run = 1; m_ptr = 0; m_num = int'(cfg_och_num); m_mode = int'(cfg_mode); m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
    if (e_wr_en) etab[e_wr_addr] = e_wr_data;
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic write_e(input int addr, input logic [E_WIDTH-1:0] data);
    e_wr_en = 1'b1; e_wr_addr = OCH_W'(addr); e_wr_data = data;
    clk_cycle();
    e_wr_en = 1'b0;
  endtask

  task automatic return_all();
    sum_valid = 1'b0; res_credit_ret = 1'b1;
    repeat (CREDITS + 2) clk_cycle();
    res_credit_ret = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] mode, input int num);
    start = 1'b1; cfg_mode = mode; cfg_och_num = (OCH_W+1)'(num);
    clk_cycle();
    start = 1'b0;
  endtask

  // Finish whatever tile is in flight, returning credits as results appear
  task automatic drain_tile();
    int n = 0;
    sum_valid = 1'b1; res_credit_ret = 1'b1;
    while ((m_run || m_drain) && n < 800) begin clk_cycle(); n++; end
    sum_valid = 1'b0; res_credit_ret = 1'b0;
    clk_cycle();
    vectors++;
    if (busy !== 1'b0 || n >= 800) begin
      miscompares++;
      $display("FAIL drain_tile busy=%b after %0d cycles, required idle", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_cycle(); clk_cycle();
    rst = 1'b0;
    vectors += 4;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || sum_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status busy=%b done=%b cfg_err=%b ready=%b, required 0000", busy, done, cfg_err, sum_ready);
    end
    if (issue !== 1'b0 || mode_out !== 4'h0 || E_set_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_issue issue=%b mode=%h eset=%h, required 0", issue, mode_out, E_set_out);
    end
    if (res_valid !== 1'b0 || res_och !== 8'h00 || res_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_res valid=%b och=%h last=%b, required 0", res_valid, res_och, res_last);
    end
    // The product pipe must also stay empty while idle after reset.
    clk_cycle(); clk_cycle();
    if (res_valid !== 1'b0 || issue !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pipe res_valid=%b issue=%b, required 0", res_valid, issue);
    end
    for (int i = 0; i < E_DEPTH; i++) write_e(i, E_WIDTH'($urandom));
  endtask

  task automatic test_mode0();
    int n_iss = 0, last_iss = -1, done_cyc = -1;
    bit e_iss, e_rv, e_rl, e_dn;
    logic [OCH_W-1:0] e_ro;
    for (int i = 0; i < 4; i++) write_e(i, E_WIDTH'(16'h0100 * (i + 1)));
    pulse_start(4'd0, 4);
    sum_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      e_iss = exp_iss.exists(k); e_rv = exp_rv.exists(k); e_dn = exp_dn.exists(k);
      e_ro = e_rv ? exp_ro[k] : '0; e_rl = e_rv ? exp_rl[k] : 1'b0;
      vectors += 6;
      if (sum_ready !== (m_run && m_cred > 0)) begin miscompares++;
        $display("FAIL mode0_ready cyc %0d got %b", k, sum_ready); end
      if (issue !== e_iss) begin miscompares++;
        $display("FAIL mode0_issue cyc %0d got %b required %b", k, issue, e_iss); end
      if (e_iss && (E_set_out !== 32'(32'h0100 * (n_iss + 1)) || mode_out !== 4'd0)) begin miscompares++;
        $display("FAIL mode0_eset cyc %0d got %h/%h required %h/0", k, E_set_out, mode_out, 32'h0100 * (n_iss + 1)); end
      if (res_valid !== e_rv || res_och !== e_ro || res_last !== e_rl) begin miscompares++;
        $display("FAIL mode0_res cyc %0d got %b/%h/%b required %b/%h/%b", k, res_valid, res_och, res_last, e_rv, e_ro, e_rl); end
      if (done !== e_dn) begin miscompares++;
        $display("FAIL mode0_done cyc %0d got %b required %b", k, done, e_dn); end
      if (busy !== (m_run || m_drain) || cfg_err !== m_err) begin miscompares++;
        $display("FAIL mode0_status cyc %0d busy=%b err=%b", k, busy, cfg_err); end
      if (issue === 1'b1) begin n_iss++; last_iss = k; end
      if (done === 1'b1) done_cyc = k;
      clk_cycle();
    end
    sum_valid = 1'b0;
    vectors += 2;
    if (n_iss != 4) begin miscompares++; $display("FAIL mode0_count issues %0d required 4", n_iss); end
    if (done_cyc - last_iss != 4) begin miscompares++;
      $display("FAIL mode0_done_lat %0d cycles after last issue, required 4", done_cyc - last_iss); end
  endtask

  task automatic test_mode1();
    logic [E_WIDTH-1:0] ev [4];
    logic [31:0] want_es [2];
    int n_iss = 0, n_res = 0;
    bit e_rv, e_rl;
    logic [OCH_W-1:0] e_ro;
    for (int i = 0; i < 4; i++) begin ev[i] = E_WIDTH'($urandom); write_e(i, ev[i]); end
    want_es[0] = {ev[1], ev[0]};
    want_es[1] = {ev[3], ev[2]};
    pulse_start(4'd1, 4);
    sum_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      e_rv = exp_rv.exists(k); e_ro = e_rv ? exp_ro[k] : '0; e_rl = e_rv ? exp_rl[k] : 1'b0;
      vectors += 4;
      if (issue !== exp_iss.exists(k)) begin miscompares++;
        $display("FAIL mode1_issue cyc %0d got %b", k, issue); end
      if (issue === 1'b1 && n_iss < 2 && (E_set_out !== want_es[n_iss] || mode_out !== 4'd1)) begin miscompares++;
        $display("FAIL mode1_eset got %h/%h required %h/1", E_set_out, mode_out, want_es[n_iss]); end
      if (res_valid === 1'b1 && res_och !== OCH_W'(2 * n_res)) begin miscompares++;
        $display("FAIL mode1_och got %h required %h", res_och, 2 * n_res); end
      if (res_valid !== e_rv || res_och !== e_ro || res_last !== e_rl || done !== exp_dn.exists(k)) begin miscompares++;
        $display("FAIL mode1_res cyc %0d got %b/%h/%b/%b", k, res_valid, res_och, res_last, done); end
      if (issue === 1'b1) n_iss++;
      if (res_valid === 1'b1) n_res++;
      clk_cycle();
    end
    sum_valid = 1'b0;
    vectors++;
    if (n_iss != 2 || n_res != 2) begin miscompares++;
      $display("FAIL mode1_count issues %0d results %0d required 2/2", n_iss, n_res); end
  endtask

  task automatic test_credits();
    int n_iss = 0;
    return_all();
    pulse_start(4'd0, 12);
    sum_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      vectors++;
      if (sum_ready !== (m_run && m_cred > 0)) begin miscompares++;
        $display("FAIL credits_ready cyc %0d got %b", k, sum_ready); end
      if (issue === 1'b1) n_iss++;
      clk_cycle();
    end
    vectors += 2;
    if (n_iss != CREDITS) begin miscompares++; $display("FAIL credits_limit handshakes %0d required %0d", n_iss, CREDITS); end
    if (sum_ready !== 1'b0) begin miscompares++; $display("FAIL credits_stall sum_ready=%b required 0", sum_ready); end
    res_credit_ret = 1'b1; clk_cycle(); res_credit_ret = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 6; c++) begin
      if (issue === 1'b1) n_iss++;
      clk_cycle();
    end
    vectors++;
    if (n_iss != 1) begin miscompares++; $display("FAIL credits_one_return handshakes %0d required 1", n_iss); end
    drain_tile();
  endtask

  task automatic test_simul_return();
    int n_iss = 0;
    return_all();
    pulse_start(4'd0, 16);
    sum_valid = 1'b1;
    for (int c = 0; c < 22; c++) begin
      res_credit_ret = (c >= 3 && c < 8);
      vectors++;
      if (sum_ready !== (m_run && m_cred > 0)) begin miscompares++;
        $display("FAIL simul_ready cyc %0d got %b", k, sum_ready); end
      if (issue === 1'b1) n_iss++;
      clk_cycle();
    end
    res_credit_ret = 1'b0;
    vectors++;
    if (n_iss != 13 || sum_ready !== 1'b0) begin miscompares++;
      $display("FAIL simul_credit handshakes %0d ready %b required 13/0", n_iss, sum_ready); end
    drain_tile();
  endtask

  task automatic test_cfg_err();
    sum_valid = 1'b0;
    pulse_start(4'd2, 4);
    vectors++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin miscompares++;
      $display("FAIL cfg_bad_mode err=%b busy=%b required 1/0", cfg_err, busy); end
    sum_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (issue !== 1'b0 || sum_ready !== 1'b0) begin miscompares++;
        $display("FAIL cfg_no_issue issue=%b ready=%b required 0/0", issue, sum_ready); end
      clk_cycle();
    end
    sum_valid = 1'b0;
    pulse_start(4'd1, 3);
    vectors++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin miscompares++;
      $display("FAIL cfg_odd_num err=%b busy=%b required 1/0", cfg_err, busy); end
    pulse_start(4'd1, 2);
    vectors++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin miscompares++;
      $display("FAIL cfg_clear err=%b busy=%b required 0/1", cfg_err, busy); end
    drain_tile();
  endtask

  task automatic test_rst_midrun();
    int n_iss = 0;
    return_all();
    pulse_start(4'd0, 8);
    sum_valid = 1'b1;
    clk_cycle(); clk_cycle();
    rst = 1'b1; clk_cycle(); rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || issue !== 1'b0) begin miscompares++;
      $display("FAIL rst_midrun busy=%b res_valid=%b issue=%b required 0", busy, res_valid, issue); end
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (done !== 1'b0 || res_valid !== 1'b0) begin miscompares++;
        $display("FAIL rst_flush cyc %0d done=%b res_valid=%b required 0", k, done, res_valid); end
      clk_cycle();
    end
    pulse_start(4'd0, 10);
    for (int c = 0; c < 14; c++) begin
      if (issue === 1'b1) n_iss++;
      clk_cycle();
    end
    vectors++;
    if (n_iss != CREDITS) begin miscompares++;
      $display("FAIL rst_credits handshakes %0d required %0d", n_iss, CREDITS); end
    drain_tile();
  endtask

  task automatic test_random();
    bit e_iss, e_rv, e_rl, e_dn;
    logic [OCH_W-1:0] e_ro;
    int r;
    for (int n = 0; n < 1500; n++) begin
      rst   = (n > 0) && ($urandom_range(0, 399) == 0);
      start = (n == 0) || ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 9);
      cfg_mode = (r < 5) ? 4'd0 : (r < 9) ? 4'd1 : 4'($urandom_range(2, 15));
      if (n == 0) begin
        cfg_mode = 4'd1; cfg_och_num = 9'd256;
      end else if ($urandom_range(0, 29) == 0) begin
        cfg_och_num = 9'd256;
      end else if (cfg_mode == 4'd1 && $urandom_range(0, 9) != 0) begin
        cfg_och_num = 9'(2 * $urandom_range(1, 12));
      end else begin
        cfg_och_num = 9'($urandom_range(1, 24));
      end
      sum_valid      = ($urandom_range(0, 3) != 0);
      res_credit_ret = ($urandom_range(0, 1) != 0);
      e_wr_en        = ($urandom_range(0, 3) == 0);
      e_wr_addr      = OCH_W'($urandom);
      e_wr_data      = E_WIDTH'($urandom);
      e_iss = exp_iss.exists(k); e_rv = exp_rv.exists(k); e_dn = exp_dn.exists(k);
      e_ro = e_rv ? exp_ro[k] : '0; e_rl = e_rv ? exp_rl[k] : 1'b0;
      vectors += 6;
      if (sum_ready !== (m_run && m_cred > 0)) begin miscompares++;
        $display("FAIL rand_ready cyc %0d got %b required %b", k, sum_ready, (m_run && m_cred > 0)); end
      if (issue !== e_iss) begin miscompares++;
        $display("FAIL rand_issue cyc %0d got %b required %b", k, issue, e_iss); end
      if (e_iss && (E_set_out !== exp_es[k] || mode_out !== exp_md[k])) begin miscompares++;
        $display("FAIL rand_eset cyc %0d got %h/%h required %h/%h", k, E_set_out, mode_out, exp_es[k], exp_md[k]); end
      if (res_valid !== e_rv || res_och !== e_ro || res_last !== e_rl) begin miscompares++;
        $display("FAIL rand_res cyc %0d got %b/%h/%b required %b/%h/%b", k, res_valid, res_och, res_last, e_rv, e_ro, e_rl); end
      if (done !== e_dn) begin miscompares++;
        $display("FAIL rand_done cyc %0d got %b required %b", k, done, e_dn); end
      if (busy !== (m_run || m_drain) || cfg_err !== m_err) begin miscompares++;
        $display("FAIL rand_status cyc %0d busy=%b err=%b required %b/%b", k, busy, cfg_err, (m_run || m_drain), m_err); end
      clk_cycle();
    end
    rst = 1'b0; start = 1'b0; e_wr_en = 1'b0;
    sum_valid = 1'b0; res_credit_ret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_mode = '0; cfg_och_num = '0;
    e_wr_en = 1'b0; e_wr_addr = '0; e_wr_data = '0;
    sum_valid = 1'b0; res_credit_ret = 1'b0;
    m_run = 0; m_drain = 0; m_err = 0; m_cred = CREDITS;
    m_ptr = 0; m_num = 0; m_mode = 0; m_done_cyc = 0;
    for (int i = 0; i < E_DEPTH; i++) etab[i] = '0;
    test_reset();
    test_mode0();
    test_mode1();
    test_credits();
    test_simul_return();
    test_cfg_err();
    test_rst_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", k);
    $fatal(1, "timeout");
  end
endmodule
